// File: rtl/modexp_controller.sv
`default_nettype none
// ============================================================================
// modexp_controller : left-to-right square-and-multiply sequencing FSM.
// Optional build macro: MODEXP_SKIP_LEADING_ZEROS_EN (start at highest set bit)
// Revision: 1.0 - initial release
// ============================================================================
module modexp_controller #(
   parameter  int EXP_WIDTH = 32,
   localparam int IDX_W     = $clog2(EXP_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_WIDTH-1:0] exponent,
   output logic                 initialize,
   output logic                 mul_start,
   input  logic                 mul_done,
   output logic                 mod_start,
   input  logic                 mod_done,
   output logic                 op_sel,
   output logic [IDX_W-1:0]     bit_idx,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INIT     = 3'd1,
      S_MUL_GO   = 3'd2,
      S_MUL_WAIT = 3'd3,
      S_MOD_GO   = 3'd4,
      S_MOD_WAIT = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   state_t                 state_q,   state_d;
   logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
   logic                   op_sel_q,  op_sel_d;
   logic [EXP_WIDTH-1:0]   exp_q,     exp_d;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
   logic [IDX_W-1:0]       msb_idx;

   // Highest set bit wins: later iterations overwrite lower indices.
   always_comb begin
      msb_idx = '0;
      for (int i = 0; i < EXP_WIDTH; i++) begin
         if (exp_q[i]) begin
            msb_idx = IDX_W'(i);
         end
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      op_sel_d  = op_sel_q;
      exp_d     = exp_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               exp_d     = exponent;
               bit_idx_d = IDX_W'(EXP_WIDTH - 1);
               state_d   = S_INIT;
            end
         end
         S_INIT: begin
            if (exp_q == '0) begin
               state_d = S_DONE;
            end else begin
               op_sel_d = 1'b0;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
               bit_idx_d = msb_idx;
`endif
               state_d  = S_MUL_GO;
            end
         end
         S_MUL_GO:   state_d = S_MUL_WAIT;
         S_MUL_WAIT: if (mul_done) state_d = S_MOD_GO;
         S_MOD_GO:   state_d = S_MOD_WAIT;
         S_MOD_WAIT: begin
            if (mod_done) begin
               // A set bit earns a multiply by base after its squaring.
               if (!op_sel_q && exp_q[bit_idx_q]) begin
                  op_sel_d = 1'b1;
                  state_d  = S_MUL_GO;
               end else if (bit_idx_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  bit_idx_d = bit_idx_q - IDX_W'(1);
                  op_sel_d  = 1'b0;
                  state_d   = S_MUL_GO;
               end
            end
         end
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bit_idx_q <= '0;
         op_sel_q  <= 1'b0;
         exp_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         op_sel_q  <= op_sel_d;
         exp_q     <= exp_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign initialize = (state_q == S_INIT);
   assign mul_start  = (state_q == S_MUL_GO);
   assign mod_start  = (state_q == S_MOD_GO);
   assign out_valid  = (state_q == S_DONE);
   assign busy       = (state_q != S_IDLE);
   assign op_sel     = op_sel_q;
   assign bit_idx    = bit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_modexp_controller.sv
`default_nettype none
// Testbench for modexp_controller: drives exponents, emulates the multiplier and
// modulo units, and checks strobe sequences and the resulting modexp value.
module tb_modexp_controller;

   localparam int W  = 8;
   localparam int IW = $clog2(W);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  exponent;
   logic          initialize;
   logic          mul_start;
   logic          mul_done;
   logic          mod_start;
   logic          mod_done;
   logic          op_sel;
   logic [IW-1:0] bit_idx;
   logic          busy;
   logic          out_valid;
   logic          out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   int exp_sel[$];
   int exp_idx[$];

   always #5 clk = ~clk;

   modexp_controller #(.EXP_WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .exponent   (exponent),
      .initialize (initialize),
      .mul_start  (mul_start),
      .mul_done   (mul_done),
      .mod_start  (mod_start),
      .mod_done   (mod_done),
      .op_sel     (op_sel),
      .bit_idx    (bit_idx),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_checks++;
      if (obs !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, req);
      end
   endtask

   // Reference schedule: one square per visited bit, plus a multiply when that bit is 1.
   task automatic build_model(input logic [W-1:0] e);
      exp_sel.delete();
      exp_idx.delete();
      if (e != '0) begin
         int start;
         start = W - 1;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
         for (int i = 0; i < W; i++) if (e[i]) start = i;
`endif
         for (int i = start; i >= 0; i--) begin
            exp_sel.push_back(0);
            exp_idx.push_back(i);
            if (e[i]) begin
               exp_sel.push_back(1);
               exp_idx.push_back(i);
            end
         end
      end
   endtask

   function automatic longint powmod(input longint b, input int e, input longint m);
      longint r;
      r = 1;
      for (int i = 0; i < e; i++) r = (r * b) % m;
      return r;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_strobes"}, {initialize, mul_start, mod_start}, 0);
   endtask

   // Caller is positioned #1 after a rising edge with the DUT idle.
   task automatic run_op(input logic [W-1:0] e, input int mul_k, input int mod_k,
                         input bit level, input int hold, input bit junk,
                         input longint base, input longint m);
      int     cyc = 0, mul_cnt = 0, mod_cnt = 0, init_cnt = 0;
      int     hold_cnt = 0, lat = -1, mul_cd = 0, mod_cd = 0, n;
      bit     seen_ov = 0, fin = 0, cur_sel = 0;
      longint acc = 0, prod = 0;
      build_model(e);
      n = exp_sel.size();
      check("accept_in_ready", in_ready, 1);
      mul_done  = level;
      mod_done  = level;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      exponent  = e;
      while (!fin && cyc < 4000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (junk) begin
            in_valid = 1'b1;
            exponent = W'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         if (level) begin
            mul_done = 1'b1;
            mod_done = 1'b1;
         end else begin
            mul_done = 1'b0;
            mod_done = 1'b0;
            if (mul_cd > 0) begin mul_cd--; if (mul_cd == 0) mul_done = 1'b1; end
            if (mod_cd > 0) begin mod_cd--; if (mod_cd == 0) mod_done = 1'b1; end
         end
         if (initialize) begin init_cnt++; acc = 1; end
         if (mul_start) begin
            if (mul_cnt < n) begin
               check("op_sel", op_sel, exp_sel[mul_cnt]);
               check("bit_idx", bit_idx, exp_idx[mul_cnt]);
            end
            prod    = op_sel ? acc * base : acc * acc;
            cur_sel = op_sel;
            mul_cnt++;
            mul_cd  = mul_k;
         end
         if (mod_start) begin
            check("op_sel_stable", op_sel, cur_sel);
            acc = prod % m;
            mod_cnt++;
            mod_cd = mod_k;
         end
         check("busy", busy, 1);
         check("in_ready_busy", in_ready, 0);
         if (out_valid) begin
            if (!seen_ov) begin seen_ov = 1; lat = cyc; end
            in_valid = 1'b0;
            if (hold_cnt < hold) begin
               hold_cnt++;
               out_ready = 1'b0;
            end else begin
               out_ready = 1'b1;
               fin = 1;
            end
         end else if (seen_ov) begin
            check("out_valid_held", out_valid, 1);
         end
      end
      if (!fin) check("timeout", 0, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      mul_done  = 1'b0;
      mod_done  = 1'b0;
      check_idle("post_done");
      check("mul_count", mul_cnt, n);
      check("mod_count", mod_cnt, n);
      check("init_count", init_cnt, 1);
      check("result", acc, powmod(base, int'(e), m));
      check("latency", lat, level ? 2 + 4 * n : 2 + n * (2 + mul_k + mod_k));
   endtask

   task automatic run_abort(input logic [W-1:0] e);
      int  cyc = 0;
      bit  got = 0;
      in_valid = 1'b1;
      exponent = e;
      mul_done = 1'b0;
      mod_done = 1'b0;
      while (!got && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         in_valid = 1'b0;
         mul_done = mul_start ? 1'b0 : busy;
         if (mod_start) got = 1;
      end
      if (!got) check("abort_timeout", 0, 1);
      @(posedge clk);
      #1;
      rst      = 1'b1;
      mul_done = 1'b1;
      mod_done = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle("abort");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check_idle("abort_quiet");
      end
      mul_done = 1'b0;
      mod_done = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      exponent  = '0;
      mul_done  = 1'b0;
      mod_done  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle("reset");
      check("reset_bit_idx", bit_idx, 0);
      check("reset_op_sel", op_sel, 0);

      run_op(8'h05, 1, 1, 0, 0, 0, 3, 7);
      run_op(8'h00, 1, 1, 0, 0, 0, 5, 11);
      run_op(8'hFF, 5, 3, 0, 4, 1, 6, 97);
      run_op(8'hA5, 1, 1, 1, 1, 0, 12, 101);
      run_abort(8'h80);
      run_op(8'h03, 1, 1, 0, 0, 0, 9, 13);

      for (int t = 0; t < 12; t++) begin
         longint m, b;
         m = longint'($urandom_range(1000, 2));
         b = longint'($urandom_range(int'(m) - 1, 0));
         run_op(W'($urandom), $urandom_range(4, 1), $urandom_range(4, 1),
                1'($urandom_range(1, 0)), $urandom_range(3, 0),
                1'($urandom_range(1, 0)), b, m);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
